// File: rtl/tim_ctr_bank_if.sv
// Control and status bundle for tim_ctr_bank: run/clear/config inputs and the
// per-channel enable, counter, wrap and match outputs.
interface tim_ctr_bank_if #(
  parameter int C_CH       = 8,
  parameter int C_CTR_W    = 4,
  parameter int C_PERIOD_W = 28,
  parameter int C_PULSE_W  = 8
);
  logic                      CLR_i;
  logic [C_CH-1:0]           RUN_i;
  logic                      SAT_i;
  logic [C_PERIOD_W-1:0]     PERIOD_i;
  logic [C_CH*C_PULSE_W-1:0] PULSE_NS_i;
  logic [C_CH*C_CTR_W-1:0]   INCS_i;
  logic [C_CH-1:0]           EN_CKS_o;
  logic [C_CH*C_CTR_W-1:0]   CTRS_o;
  logic [C_CH-1:0]           WRAP_o;
  logic [C_CH-1:0]           MATCHES_o;

  modport slave (
    input  CLR_i, RUN_i, SAT_i, PERIOD_i, PULSE_NS_i, INCS_i,
    output EN_CKS_o, CTRS_o, WRAP_o, MATCHES_o
  );

  modport master (
    output CLR_i, RUN_i, SAT_i, PERIOD_i, PULSE_NS_i, INCS_i,
    input  EN_CKS_o, CTRS_o, WRAP_o, MATCHES_o
  );
endinterface

// File: rtl/tim_ctr_bank.sv
// N-channel fractional-rate timer/counter bank with adjacent-channel match flags.
// Define TIM_CTR_BANK_MATCH_STICKY_EN to latch match flags until clear or reset.
module tim_ctr_bank #(
  parameter int C_CH       = 8,
  parameter int C_CTR_W    = 4,
  parameter int C_PERIOD_W = 28,
  parameter int C_PULSE_W  = 8
) (
  input logic           CK_i,
  input logic           XARST_i,
  tim_ctr_bank_if.slave bus
);

  typedef logic [C_PERIOD_W-1:0] acc_t;
  typedef logic [C_CTR_W-1:0]    ctr_t;

  acc_t            acc_q [C_CH];
  acc_t            acc_d [C_CH];
  ctr_t            ctr_q [C_CH];
  ctr_t            ctr_d [C_CH];
  logic [C_CH-1:0] en_ck_q, en_ck_d;
  logic [C_CH-1:0] wrap_q, wrap_d;
  logic [C_CH-1:0] match_q, match_d;
  logic [C_CH*C_CTR_W-1:0] ctrs_flat;

  // Returns {pulse, next_acc}. Comparing acc against (period - pulse) is the same
  // test as acc + pulse >= period but needs no extra carry bit.
  function automatic logic [C_PERIOD_W:0] div_step(input acc_t acc, input acc_t pulse,
                                                   input acc_t period);
    logic [C_PERIOD_W:0] res;
    acc_t                gap;
    gap = period - pulse;
    if (pulse >= period) begin
      res = {1'b1, {C_PERIOD_W{1'b0}}};
    end else if (acc >= gap) begin
      res = {1'b1, acc - gap};
    end else begin
      res = {1'b0, acc + pulse};
    end
    return res;
  endfunction

  // Returns {wrap, next_ctr} for one counted enable in wrap or saturate mode.
  function automatic logic [C_CTR_W:0] ctr_step(input ctr_t ctr, input ctr_t inc,
                                                input logic sat);
    logic [C_CTR_W:0] sum;
    ctr_t             ones;
    ctr_t             nxt;
    logic             wrap;
    ones = '1;
    sum  = {1'b0, ctr} + {1'b0, inc};
    if (sat) begin
      nxt  = sum[C_CTR_W] ? ones : sum[C_CTR_W-1:0];
      wrap = (ctr != ones) && (nxt == ones);
    end else begin
      nxt  = sum[C_CTR_W-1:0];
      wrap = sum[C_CTR_W];
    end
    return {wrap, nxt};
  endfunction

  // Stage 1: divider -> en_ck; stage 2: en_ck -> counter/wrap; stage 3: counter -> match
  always_comb begin
    logic [C_PERIOD_W:0] dstep;
    logic [C_CTR_W:0]    cstep;
    logic                cmp;
    dstep = '0;
    cstep = '0;
    cmp   = 1'b0;
    for (int i = 0; i < C_CH; i++) begin
      acc_d[i]   = acc_q[i];
      en_ck_d[i] = 1'b0;
      ctr_d[i]   = ctr_q[i];
      wrap_d[i]  = 1'b0;
      cmp        = (ctr_q[i] == ctr_q[(i + C_CH - 1) % C_CH]);
`ifdef TIM_CTR_BANK_MATCH_STICKY_EN
      match_d[i] = match_q[i] | cmp;
`else
      match_d[i] = cmp;
`endif
      if (bus.CLR_i) begin
        acc_d[i]   = '0;
        ctr_d[i]   = '0;
        match_d[i] = 1'b0;
      end else begin
        if (bus.RUN_i[i] && (bus.PERIOD_i != '0)) begin
          dstep      = div_step(acc_q[i], acc_t'(bus.PULSE_NS_i[i*C_PULSE_W +: C_PULSE_W]),
                                bus.PERIOD_i);
          en_ck_d[i] = dstep[C_PERIOD_W];
          acc_d[i]   = dstep[C_PERIOD_W-1:0];
        end
        // A registered enable is applied even if RUN has since dropped
        if (en_ck_q[i]) begin
          cstep     = ctr_step(ctr_q[i], bus.INCS_i[i*C_CTR_W +: C_CTR_W], bus.SAT_i);
          ctr_d[i]  = cstep[C_CTR_W-1:0];
          wrap_d[i] = cstep[C_CTR_W];
        end
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int i = 0; i < C_CH; i++) begin
        acc_q[i] <= '0;
        ctr_q[i] <= '0;
      end
      en_ck_q <= '0;
      wrap_q  <= '0;
      match_q <= '0;
    end else begin
      for (int i = 0; i < C_CH; i++) begin
        acc_q[i] <= acc_d[i];
        ctr_q[i] <= ctr_d[i];
      end
      en_ck_q <= en_ck_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    ctrs_flat = '0;
    for (int i = 0; i < C_CH; i++) begin
      ctrs_flat[i*C_CTR_W +: C_CTR_W] = ctr_q[i];
    end
  end

  assign bus.EN_CKS_o  = en_ck_q;
  assign bus.CTRS_o    = ctrs_flat;
  assign bus.WRAP_o    = wrap_q;
  assign bus.MATCHES_o = match_q;

endmodule
